// File: rtl/pic_pkg.sv
// pic_pkg: shared definitions for the PIC command-write front end.
//   pic_state_e      : initialization sequencer states
//   ICW1_* / ICW4_*  : bit positions inside the ICW1 / ICW4 data bytes
//   OCW_SEL_BIT      : din bit that tells OCW3 (1) from OCW2 (0)
package pic_pkg;

   typedef enum logic [2:0] {
      ST_UNINIT,
      ST_WAIT_ICW2,
      ST_WAIT_ICW3,
      ST_WAIT_ICW4,
      ST_READY
   } pic_state_e;

   localparam int unsigned ICW1_IC4  = 0;
   localparam int unsigned ICW1_SNGL = 1;
   localparam int unsigned ICW1_ADI  = 2;
   localparam int unsigned ICW1_LTIM = 3;
   localparam int unsigned ICW1_FLAG = 4;

   localparam int unsigned ICW4_UPM  = 0;
   localparam int unsigned ICW4_AEOI = 1;
   localparam int unsigned ICW4_MS   = 2;
   localparam int unsigned ICW4_BUF  = 3;
   localparam int unsigned ICW4_SFNM = 4;

   localparam int unsigned OCW_SEL_BIT = 3;

endpackage

// File: rtl/pic_wr_strobe_detect.sv
// pic_wr_strobe_detect: turns the CPU write strobe (cs_n & wr_n low) into a
// single-cycle event and presents the A0/data sampled in that cycle.
//   i_clk, i_rst    : clock, async active-high reset
//   i_cs_n, i_wr_n  : chip select / write strobe, active low
//   i_a0, i_din     : register select and data bus
//   o_wr_evt        : one-cycle pulse on the first cycle of a write strobe
//   o_a0, o_din     : A0 / data qualified by o_wr_evt
module pic_wr_strobe_detect (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_cs_n,
   input  logic       i_wr_n,
   input  logic       i_a0,
   input  logic [7:0] i_din,
   output logic       o_wr_evt,
   output logic       o_a0,
   output logic [7:0] o_din
);

   logic w_wr_act;
   logic r_wr_act_q;

   assign w_wr_act = ~i_cs_n & ~i_wr_n;

   // Resets to 1 so a strobe already held low when reset releases is not
   // mistaken for a fresh write.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_wr_act_q <= 1'b1;
      else       r_wr_act_q <= w_wr_act;
   end

   assign o_wr_evt = w_wr_act & ~r_wr_act_q;
   assign o_a0     = i_a0;
   assign o_din    = i_din;

endmodule

// File: rtl/pic_init_sequencer.sv
// pic_init_sequencer: 8259-style command-write front end. Walks the
// ICW1 -> ICW2 -> [ICW3] -> [ICW4] sequence, then routes OCW1/OCW2/OCW3.
//   clk, rst              : clock, async active-high reset
//   cs_n, wr_n, a0, din   : CPU write interface
//   ltim, adi, sngl, ic4  : ICW1 fields
//   vec_base              : ICW2 T7..T3
//   cas_cfg               : ICW3 raw byte
//   upm..sfnm             : ICW4 fields
//   imr                   : OCW1 interrupt mask
//   ocw_strobe/sel/data   : one-cycle OCW2/OCW3 write notification
//   init_done             : high in READY
//   protocol_err          : one-cycle pulse on an illegal write
module pic_init_sequencer
   import pic_pkg::*;
#(
   parameter logic [7:0] IMR_INIT    = 8'h00,
   parameter logic       REQUIRE_UPM = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs_n,
   input  logic       wr_n,
   input  logic       a0,
   input  logic [7:0] din,
   output logic       ltim,
   output logic       adi,
   output logic       sngl,
   output logic       ic4,
   output logic [4:0] vec_base,
   output logic [7:0] cas_cfg,
   output logic       upm,
   output logic       aeoi,
   output logic       buf_mode,
   output logic       m_s,
   output logic       sfnm,
   output logic [7:0] imr,
   output logic       ocw_strobe,
   output logic       ocw_sel,
   output logic [7:0] ocw_data,
   output logic       init_done,
   output logic       protocol_err
);

   logic       w_evt;
   logic       w_a0;
   logic [7:0] w_din;

   pic_wr_strobe_detect u_wr_detect (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_cs_n   (cs_n),
      .i_wr_n   (wr_n),
      .i_a0     (a0),
      .i_din    (din),
      .o_wr_evt (w_evt),
      .o_a0     (w_a0),
      .o_din    (w_din)
   );

   pic_state_e r_state, w_state_nxt;
   logic w_icw1, w_icw2, w_icw3, w_icw4, w_ocw1, w_ocw23, w_err;

   logic       r_ltim, r_adi, r_sngl, r_ic4;
   logic [4:0] r_vec_base;
   logic [7:0] r_cas_cfg;
   logic       r_upm, r_aeoi, r_buf_mode, r_m_s, r_sfnm;
   logic [7:0] r_imr;
   logic       r_ocw_strobe, r_ocw_sel;
   logic [7:0] r_ocw_data;
   logic       r_init_done, r_protocol_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_UNINIT;
      else     r_state <= w_state_nxt;
   end

   // ICW1 is recognised in every state and takes precedence over the
   // per-state decode, so it restarts the sequence from anywhere.
   always_comb begin
      w_state_nxt = r_state;
      w_icw1      = 1'b0;
      w_icw2      = 1'b0;
      w_icw3      = 1'b0;
      w_icw4      = 1'b0;
      w_ocw1      = 1'b0;
      w_ocw23     = 1'b0;
      w_err       = 1'b0;
      if (w_evt) begin
         if (!w_a0 && w_din[ICW1_FLAG]) begin
            w_icw1      = 1'b1;
            w_state_nxt = ST_WAIT_ICW2;
         end else begin
            case (r_state)
               ST_WAIT_ICW2: begin
                  if (w_a0) begin
                     w_icw2 = 1'b1;
                     if (!r_sngl)    w_state_nxt = ST_WAIT_ICW3;
                     else if (r_ic4) w_state_nxt = ST_WAIT_ICW4;
                     else            w_state_nxt = ST_READY;
                  end else begin
                     w_err = 1'b1;
                  end
               end
               ST_WAIT_ICW3: begin
                  if (w_a0) begin
                     w_icw3      = 1'b1;
                     w_state_nxt = r_ic4 ? ST_WAIT_ICW4 : ST_READY;
                  end else begin
                     w_err = 1'b1;
                  end
               end
               ST_WAIT_ICW4: begin
                  if (w_a0) begin
                     w_icw4      = 1'b1;
                     w_state_nxt = ST_READY;
                     w_err       = REQUIRE_UPM & ~w_din[ICW4_UPM];
                  end else begin
                     w_err = 1'b1;
                  end
               end
               ST_READY: begin
                  if (w_a0) w_ocw1  = 1'b1;
                  else      w_ocw23 = 1'b1;
               end
               default: w_err = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ltim         <= 1'b0;
         r_adi          <= 1'b0;
         r_sngl         <= 1'b0;
         r_ic4          <= 1'b0;
         r_vec_base     <= '0;
         r_cas_cfg      <= '0;
         r_upm          <= 1'b0;
         r_aeoi         <= 1'b0;
         r_buf_mode     <= 1'b0;
         r_m_s          <= 1'b0;
         r_sfnm         <= 1'b0;
         r_imr          <= IMR_INIT;
         r_ocw_strobe   <= 1'b0;
         r_ocw_sel      <= 1'b0;
         r_ocw_data     <= '0;
         r_init_done    <= 1'b0;
         r_protocol_err <= 1'b0;
      end else begin
         r_ocw_strobe   <= w_ocw23;
         r_protocol_err <= w_err;
         r_init_done    <= (w_state_nxt == ST_READY);
         if (w_icw1) begin
            r_ltim     <= w_din[ICW1_LTIM];
            r_adi      <= w_din[ICW1_ADI];
            r_sngl     <= w_din[ICW1_SNGL];
            r_ic4      <= w_din[ICW1_IC4];
            r_imr      <= IMR_INIT;
            r_cas_cfg  <= '0;
            r_upm      <= 1'b0;
            r_aeoi     <= 1'b0;
            r_buf_mode <= 1'b0;
            r_m_s      <= 1'b0;
            r_sfnm     <= 1'b0;
         end
         if (w_icw2) r_vec_base <= w_din[7:3];
         if (w_icw3) r_cas_cfg  <= w_din;
         if (w_icw4) begin
            r_upm      <= w_din[ICW4_UPM];
            r_aeoi     <= w_din[ICW4_AEOI];
            r_m_s      <= w_din[ICW4_MS];
            r_buf_mode <= w_din[ICW4_BUF];
            r_sfnm     <= w_din[ICW4_SFNM];
         end
         if (w_ocw1) r_imr <= w_din;
         if (w_ocw23) begin
            r_ocw_sel  <= w_din[OCW_SEL_BIT];
            r_ocw_data <= w_din;
         end
      end
   end

   assign ltim         = r_ltim;
   assign adi          = r_adi;
   assign sngl         = r_sngl;
   assign ic4          = r_ic4;
   assign vec_base     = r_vec_base;
   assign cas_cfg      = r_cas_cfg;
   assign upm          = r_upm;
   assign aeoi         = r_aeoi;
   assign buf_mode     = r_buf_mode;
   assign m_s          = r_m_s;
   assign sfnm         = r_sfnm;
   assign imr          = r_imr;
   assign ocw_strobe   = r_ocw_strobe;
   assign ocw_sel      = r_ocw_sel;
   assign ocw_data     = r_ocw_data;
   assign init_done    = r_init_done;
   assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Testbench for pic_init_sequencer: table of writes with expected outputs,
// applied through a scoreboard queue, plus hand-written held-strobe and
// asynchronous-reset sequences.
module tb_pic_init_sequencer;

   localparam logic [7:0] IMR_RST = 8'h5A;

   logic       clk = 1'b0;
   logic       rst;
   logic       cs_n, wr_n, a0;
   logic [7:0] din;
   logic       ltim, adi, sngl, ic4;
   logic [4:0] vec_base;
   logic [7:0] cas_cfg;
   logic       upm, aeoi, buf_mode, m_s, sfnm;
   logic [7:0] imr;
   logic       ocw_strobe, ocw_sel;
   logic [7:0] ocw_data;
   logic       init_done, protocol_err;

   always #5 clk = ~clk;

   pic_init_sequencer #(
      .IMR_INIT    (IMR_RST),
      .REQUIRE_UPM (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cs_n         (cs_n),
      .wr_n         (wr_n),
      .a0           (a0),
      .din          (din),
      .ltim         (ltim),
      .adi          (adi),
      .sngl         (sngl),
      .ic4          (ic4),
      .vec_base     (vec_base),
      .cas_cfg      (cas_cfg),
      .upm          (upm),
      .aeoi         (aeoi),
      .buf_mode     (buf_mode),
      .m_s          (m_s),
      .sfnm         (sfnm),
      .imr          (imr),
      .ocw_strobe   (ocw_strobe),
      .ocw_sel      (ocw_sel),
      .ocw_data     (ocw_data),
      .init_done    (init_done),
      .protocol_err (protocol_err)
   );

   // icw1 = {ltim,adi,sngl,ic4}; icw4 = {sfnm,buf_mode,m_s,aeoi,upm}
   typedef struct packed {
      logic [3:0] icw1;
      logic [4:0] vec;
      logic [7:0] cas;
      logic [4:0] icw4;
      logic [7:0] imr;
      logic       done;
      logic       err;
      logic       stb;
   } obs_t;

   typedef struct {
      logic       a0;
      logic [7:0] din;
      obs_t       exp;
      logic [7:0] od;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t tbl[$];
   vec_t exp_q[$];

   function automatic vec_t mkv(input logic a, input logic [7:0] d,
                                input logic [3:0] i1, input logic [4:0] v,
                                input logic [7:0] c, input logic [4:0] i4,
                                input logic [7:0] m, input logic dn,
                                input logic er, input logic sb,
                                input logic [7:0] od);
      vec_t r;
      r.a0  = a;
      r.din = d;
      r.exp = '{icw1: i1, vec: v, cas: c, icw4: i4, imr: m,
                done: dn, err: er, stb: sb};
      r.od  = od;
      return r;
   endfunction

   function automatic obs_t get_obs();
      obs_t o;
      o.icw1 = {ltim, adi, sngl, ic4};
      o.vec  = vec_base;
      o.cas  = cas_cfg;
      o.icw4 = {sfnm, buf_mode, m_s, aeoi, upm};
      o.imr  = imr;
      o.done = init_done;
      o.err  = protocol_err;
      o.stb  = ocw_strobe;
      return o;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic do_wr(input logic a, input logic [7:0] d);
      @(negedge clk);
      cs_n = 1'b0; wr_n = 1'b0; a0 = a; din = d;
      @(negedge clk);
      cs_n = 1'b1; wr_n = 1'b1;
   endtask

   // Hold the strobe low for n cycles and count pulse cycles seen.
   task automatic held_wr(input logic a, input logic [7:0] d, input int n,
                          output int n_stb, output int n_err);
      n_stb = 0;
      n_err = 0;
      @(negedge clk);
      cs_n = 1'b0; wr_n = 1'b0; a0 = a; din = d;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (ocw_strobe)   n_stb++;
         if (protocol_err) n_err++;
      end
      cs_n = 1'b1; wr_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      obs_t rst_obs;
      vec_t e;
      int   ns, ne;

      rst_obs = '{icw1: 4'h0, vec: 5'h00, cas: 8'h00, icw4: 5'h00, imr: IMR_RST,
                  done: 1'b0, err: 1'b0, stb: 1'b0};

      //             a0  din    icw1  vec    cas    icw4   imr    dn er sb od
      tbl.push_back(mkv(1, 8'h55, 4'h0, 5'h00, 8'h00, 5'h00, 8'h5A, 0, 1, 0, 8'h00));
      tbl.push_back(mkv(0, 8'h05, 4'h0, 5'h00, 8'h00, 5'h00, 8'h5A, 0, 1, 0, 8'h00));
      tbl.push_back(mkv(0, 8'h11, 4'h1, 5'h00, 8'h00, 5'h00, 8'h5A, 0, 0, 0, 8'h00));
      tbl.push_back(mkv(1, 8'h40, 4'h1, 5'h08, 8'h00, 5'h00, 8'h5A, 0, 0, 0, 8'h00));
      tbl.push_back(mkv(0, 8'h00, 4'h1, 5'h08, 8'h00, 5'h00, 8'h5A, 0, 1, 0, 8'h00));
      tbl.push_back(mkv(1, 8'h04, 4'h1, 5'h08, 8'h04, 5'h00, 8'h5A, 0, 0, 0, 8'h00));
      tbl.push_back(mkv(1, 8'h03, 4'h1, 5'h08, 8'h04, 5'h03, 8'h5A, 1, 0, 0, 8'h00));
      tbl.push_back(mkv(1, 8'hF0, 4'h1, 5'h08, 8'h04, 5'h03, 8'hF0, 1, 0, 0, 8'h00));
      tbl.push_back(mkv(0, 8'h20, 4'h1, 5'h08, 8'h04, 5'h03, 8'hF0, 1, 0, 1, 8'h20));
      tbl.push_back(mkv(0, 8'h0B, 4'h1, 5'h08, 8'h04, 5'h03, 8'hF0, 1, 0, 1, 8'h0B));
      tbl.push_back(mkv(0, 8'h1A, 4'hA, 5'h08, 8'h00, 5'h00, 8'h5A, 0, 0, 0, 8'h00));
      tbl.push_back(mkv(1, 8'h08, 4'hA, 5'h01, 8'h00, 5'h00, 8'h5A, 1, 0, 0, 8'h00));
      tbl.push_back(mkv(0, 8'h11, 4'h1, 5'h01, 8'h00, 5'h00, 8'h5A, 0, 0, 0, 8'h00));
      tbl.push_back(mkv(1, 8'h40, 4'h1, 5'h08, 8'h00, 5'h00, 8'h5A, 0, 0, 0, 8'h00));
      tbl.push_back(mkv(0, 8'h13, 4'h3, 5'h08, 8'h00, 5'h00, 8'h5A, 0, 0, 0, 8'h00));
      tbl.push_back(mkv(1, 8'h48, 4'h3, 5'h09, 8'h00, 5'h00, 8'h5A, 0, 0, 0, 8'h00));
      tbl.push_back(mkv(1, 8'h02, 4'h3, 5'h09, 8'h00, 5'h02, 8'h5A, 1, 1, 0, 8'h00));
      tbl.push_back(mkv(1, 8'h3C, 4'h3, 5'h09, 8'h00, 5'h02, 8'h3C, 1, 0, 0, 8'h00));
      tbl.push_back(mkv(0, 8'h10, 4'h0, 5'h09, 8'h00, 5'h00, 8'h5A, 0, 0, 0, 8'h00));
      tbl.push_back(mkv(1, 8'hF8, 4'h0, 5'h1F, 8'h00, 5'h00, 8'h5A, 0, 0, 0, 8'h00));
      tbl.push_back(mkv(1, 8'h80, 4'h0, 5'h1F, 8'h80, 5'h00, 8'h5A, 1, 0, 0, 8'h00));

      rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_state", get_obs(), rst_obs);
      rst = 1'b0;

      foreach (tbl[i]) begin
         exp_q.push_back(tbl[i]);
         do_wr(tbl[i].a0, tbl[i].din);
         e = exp_q.pop_front();
         chk($sformatf("row%0d", i), get_obs(), e.exp);
         if (e.exp.stb) begin
            chk($sformatf("row%0d_ocw_data", i), ocw_data, e.od);
            chk($sformatf("row%0d_ocw_sel", i), ocw_sel, e.od[3]);
         end
         @(negedge clk);
         chk($sformatf("row%0d_pulse_end", i), {ocw_strobe, protocol_err}, 2'b00);
      end

      // Held OCW2 strobe in READY: exactly one strobe cycle.
      held_wr(1'b0, 8'h20, 10, ns, ne);
      chk("held_ocw2_strobes", ns, 1);

      // Held ICW2 with cascade+ICW4: a repeat would be taken as ICW3.
      do_wr(1'b0, 8'h11);
      held_wr(1'b1, 8'h10, 10, ns, ne);
      chk("held_icw2", {vec_base, cas_cfg, init_done}, {5'h02, 8'h00, 1'b0});
      chk("held_icw2_err", ne, 0);
      do_wr(1'b1, 8'h00);
      // Held ICW4: a repeat in READY would load the IMR.
      held_wr(1'b1, 8'h01, 10, ns, ne);
      chk("held_icw4", {imr, init_done, sfnm, buf_mode, m_s, aeoi, upm},
          {IMR_RST, 1'b1, 5'h01});
      chk("held_icw4_err", ne, 0);

      // Async reset while waiting for ICW3, asserted between clock edges.
      do_wr(1'b0, 8'h11);
      do_wr(1'b1, 8'h40);
      chk("pre_reset_vec", {vec_base, init_done}, {5'h08, 1'b0});
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("async_reset", get_obs(), rst_obs);
      cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'hFF;
      @(negedge clk);
      rst = 1'b0;
      ne = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (protocol_err) ne++;
      end
      chk("strobe_at_release_err", ne, 0);
      chk("strobe_at_release_state", get_obs(), rst_obs);
      cs_n = 1'b1; wr_n = 1'b1;
      do_wr(1'b0, 8'h13);
      chk("post_reset_icw1", {ltim, adi, sngl, ic4, imr, init_done},
          {4'h3, IMR_RST, 1'b0});
      do_wr(1'b1, 8'h48);
      chk("post_reset_icw2", {vec_base, init_done}, {5'h09, 1'b0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
